// File: rtl/demux1x4_sched.sv
// rtl/demux1x4_sched.sv - one-entry buffered 1-to-4 demux scheduler
// Round-robin bursts or fixed destination, with stall-timeout redirect.
module demux1x4_sched #(
    parameter int W       = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [1:0]   fixed_dst,
    input  logic [3:0]   out_ready,
    output logic [3:0]   out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   sel,
    output logic         timeout
);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int SW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(BURST - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    logic [W-1:0]  r_buf_data;
    logic          r_full;
    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [BW-1:0] r_beat_cnt;
    logic [SW-1:0] r_stall_cnt;
    logic          r_timeout;
    logic          r_to_done;

    logic          w_drain;
    logic          w_stall;
    logic          w_accept;
    logic          w_at_limit;
    logic          w_fire;
    logic [1:0]    w_dest;

    assign w_drain    = r_full & out_ready[r_sel];
    assign w_stall    = r_full & ~out_ready[r_sel];
    assign in_ready   = rst_n & (~r_full | w_drain);
    assign w_accept   = in_valid & in_ready;
    assign w_at_limit = (r_stall_cnt == STALL_MAX);
    // In fixed mode a stall reports once; r_to_done blocks repeats until it clears.
    assign w_fire     = w_stall & w_at_limit & ~(mode & r_to_done);
    assign w_dest     = mode ? fixed_dst : r_ptr;

    assign out_valid  = r_full ? (4'b0001 << r_sel) : 4'b0000;
    assign out_data   = r_buf_data;
    assign sel        = r_sel;
    assign timeout    = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data  <= '0;
            r_full      <= 1'b0;
            r_sel       <= 2'd0;
            r_ptr       <= 2'd0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
            r_to_done   <= 1'b0;
        end else begin
            r_timeout <= w_fire;

            if (!w_stall)
                r_to_done <= 1'b0;
            else if (w_fire && mode)
                r_to_done <= 1'b1;

            if (!w_stall)
                r_stall_cnt <= '0;
            else if (w_fire && !mode)
                r_stall_cnt <= '0;
            else if (!w_at_limit)
                r_stall_cnt <= r_stall_cnt + 1'b1;

            if (w_accept) begin
                r_buf_data <= in_data;
                r_full     <= 1'b1;
                r_sel      <= w_dest;
                if (!mode) begin
                    if (r_beat_cnt == BEAT_MAX) begin
                        r_beat_cnt <= '0;
                        r_ptr      <= r_ptr + 2'd1;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            end else begin
                if (w_drain)
                    r_full <= 1'b0;
                // Redirect keeps the word; only its destination moves on.
                if (w_fire && !mode) begin
                    r_sel      <= r_sel + 2'd1;
                    r_ptr      <= r_sel + 2'd1;
                    r_beat_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_demux1x4_sched.sv
// tb/tb_demux1x4_sched.sv - self-checking bench for demux1x4_sched
module tb_demux1x4_sched;
    localparam int W       = 8;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [1:0]   fixed_dst = 2'd0;
    logic [3:0]   out_ready = 4'd0;
    logic [3:0]   out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   sel;
    logic         timeout;

    demux1x4_sched #(.W(W), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .fixed_dst(fixed_dst),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a held word with a destination; round-robin destination is
    // base + (accepts since base)/BURST, rebased whenever a redirect happens.
    bit m_held = 0, m_latched = 0, m_to = 0;
    int m_word = 0, m_dest = 0, m_base = 0, m_acc = 0, m_wait = 0;
    bit t_deliver, t_stalled, t_take, t_fire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held = 0; m_latched = 0; m_to = 0;
            m_word = 0; m_dest = 0; m_base = 0; m_acc = 0; m_wait = 0;
        end else begin
            t_stalled = m_held && !out_ready[m_dest];
            t_deliver = m_held && out_ready[m_dest];
            t_take    = in_valid && (!m_held || t_deliver);
            t_fire    = t_stalled && (m_wait == TIMEOUT - 1) && !(mode && m_latched);
            m_to      = t_fire;
            if (!t_stalled) begin
                m_wait = 0;
                m_latched = 0;
            end else if (t_fire) begin
                if (mode) m_latched = 1;
                else begin
                    m_dest = (m_dest + 1) % 4;
                    m_base = m_dest;
                    m_acc  = 0;
                    m_wait = 0;
                end
            end else if (m_wait < TIMEOUT - 1) begin
                m_wait++;
            end
            if (t_take) begin
                m_word = in_data;
                m_held = 1;
                if (mode) m_dest = fixed_dst;
                else begin
                    m_dest = (m_base + m_acc / BURST) % 4;
                    m_acc++;
                end
            end else if (t_deliver) begin
                m_held = 0;
            end
        end
    end

    int sb[$];
    int log_data[$];
    int log_sel[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_timeout", timeout, 0);
            sb.delete();
        end else begin
            chk("out_valid", out_valid, m_held ? (1 << m_dest) : 0);
            chk("out_data", out_data, m_word);
            chk("in_ready", in_ready, (!m_held || out_ready[m_dest]) ? 1 : 0);
            chk("sel", sel, m_dest);
            chk("timeout", timeout, m_to);
            if (out_valid[sel] && out_ready[sel]) begin
                log_data.push_back(out_data);
                log_sel.push_back(sel);
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) chk("sb_order", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        #0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_wait_bound", g < 50, 1);
        tick();
        in_valid = 1'b0;
    endtask

    int lsz, pulses, at, accepted, cyc;
    logic [3:0] force0, force1;

    initial begin
        tick(); tick();
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        out_ready = 4'hF;

        // Continuous round-robin stream
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            #0;
            chk("t1_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("t1_count", log_data.size(), 12);
        for (int i = 0; i < 12 && i < log_data.size(); i++) begin
            chk("t1_data", log_data[i], 32'h10 + i);
            chk("t1_sel", log_sel[i], i / 4);
        end

        // Fixed mode then back to round-robin
        lsz = log_data.size();
        mode = 1'b1; fixed_dst = 2'd3;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h20 + 8'(i); tick();
        end
        mode = 1'b0;
        for (int i = 5; i < 13; i++) begin
            in_valid = 1'b1; in_data = 8'h20 + 8'(i); tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("t2_count", log_data.size(), lsz + 13);
        if (log_data.size() >= lsz + 13) begin
            for (int i = 0; i < 5; i++) chk("t2_fixed_sel", log_sel[lsz + i], 3);
            chk("t2_resume_sel", log_sel[lsz + 5], 3);
            chk("t2_wrap_sel", log_sel[lsz + 9], 0);
        end

        // Round-robin stall on dest 1 and redirect
        out_ready = 4'b1101;
        send(8'hAA);
        chk("t3_sel", sel, 1);
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("t3_stall_in_ready", in_ready, 0);
            chk("t3_no_pulse", timeout, 0);
            tick();
        end
        chk("t3_pulse", timeout, 1);
        chk("t3_redirect_sel", sel, 2);
        chk("t3_redirect_valid", out_valid, 4'b0100);
        tick();
        chk("t3_pulse_end", timeout, 0);
        chk("t3_drained_data", log_data[log_data.size() - 1], 8'hAA);
        chk("t3_drained_sel", log_sel[log_data.size() - 1], 2);
        send(8'hAB);
        chk("t3_next_sel", sel, 2);
        out_ready = 4'hF;
        tick();

        // Fixed-mode stall: single pulse, word held
        mode = 1'b1; fixed_dst = 2'd0; out_ready = 4'b1110;
        send(8'hAA);
        pulses = 0; at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (timeout) begin pulses++; at = i; end
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_pulse_at", at, 8);
        chk("t4_held", out_valid, 4'b0001);
        lsz = log_data.size();
        out_ready = 4'hF;
        tick(); tick();
        chk("t4_once", log_data.size(), lsz + 1);
        chk("t4_data", log_data[log_data.size() - 1], 8'hAA);
        chk("t4_sel", log_sel[log_data.size() - 1], 0);

        // Alternating back-pressure with continuous input
        mode = 1'b0;
        lsz = log_data.size();
        accepted = 0; cyc = 0;
        while (accepted < 32 && cyc < 300) begin
            out_ready = cyc[0] ? 4'hF : 4'h0;
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            #1;
            if (in_ready) accepted++;
            tick();
            cyc++;
        end
        chk("t5_accepted", accepted, 32);
        in_valid = 1'b0; out_ready = 4'hF;
        tick(); tick(); tick();
        chk("t5_delivered", log_data.size() - lsz, 32);
        chk("t5_sb_empty", sb.size(), 0);

        // Random traffic, mode and stall patterns
        force0 = 4'h0; force1 = 4'h0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                mode      = 1'($urandom);
                fixed_dst = 2'($urandom);
                force0    = 4'($urandom) & 4'($urandom);
                force1    = 4'($urandom) & ~force0;
            end
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            out_ready = (4'($urandom) | force1) & ~force0;
            tick();
        end
        in_valid = 1'b0; out_ready = 4'hF;
        tick(); tick(); tick();
        chk("rand_sb_empty", sb.size(), 0);

        // Asynchronous reset while full
        mode = 1'b0; out_ready = 4'h0;
        send(8'h55);
        chk("t6_full", out_valid != 4'b0000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 4'b0000);
        chk("t6_async_ready", in_ready, 0);
        chk("t6_async_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h70 + 8'(i);
            tick();
            chk("t6_sel", sel, (i < 4) ? 0 : 1);
        end
        in_valid = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demux1x4_sched.md
Name: demux1x4_sched

Overview:
- Scheduler/controller for the 1-to-4 demultiplexer datapath.
- Accepts one input word stream with a valid/ready handshake, holds each word in a one-entry output buffer, and drives the demux select to steer the word to one of four destinations.
- Two modes:
  - Mode 0 (round-robin): bursts of BURST words per destination. A word stuck on a stalled destination is redirected after a timeout.
  - Mode 1 (fixed): every word goes to cfg-selected destination fixed_dst.

Parameters:
- W, 8, data width.
- BURST, 4, words sent to one destination before the round-robin pointer advances (≥1).
- TIMEOUT, 8, consecutive stall cycles before the timeout action (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  W  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept in_data this cycle.
- mode  input  1  0 = round-robin, 1 = fixed destination.
- fixed_dst  input  2  destination used in mode 1.
- out_ready  input  4  per-destination ready.
- out_valid  output  4  one-hot per-destination valid.
- out_data  output  W  buffered word, shared by all destinations.
- sel  output  2  demux select; destination of the buffered word.
- timeout  output  1  one-cycle pulse on a stall timeout.

Behaviour:
- State registers: buf_data, full, sel, ptr[1:0], beat_cnt, stall_cnt.
- Reset (async, while rst_n=0): full=0, sel=0, ptr=0, beat_cnt=0, stall_cnt=0, buf_data=0, timeout=0. Outputs during reset: out_valid=0000, out_data=0, in_ready=0.
- Combinational outputs:
  - out_valid[k] = full & (sel==k).
  - out_data = buf_data.
  - drain = full & out_ready[sel].
  - in_ready = rst_n & (~full | drain).
- Accept = in_valid & in_ready.
  - On accept: buf_data<=in_data; full<=1; sel<=dest, where dest = mode ? fixed_dst : ptr (sampled in the accept cycle).
  - Latency: word visible on out_data / out_valid the cycle after accept.
- Drain without accept: full<=0. sel holds its value while empty.
- Simultaneous drain and accept: buffer reloads, full stays 1. This gives full throughput of 1 word/cycle.
- Round-robin (mode 0), on each accept:
  - If beat_cnt==BURST-1: beat_cnt<=0 and ptr<=ptr+1 (3 wraps to 0).
  - Otherwise beat_cnt<=beat_cnt+1.
- In mode 1, ptr and beat_cnt hold. A mode switch takes effect at the next accept; ptr and beat_cnt are not cleared.
- Stall counting: when full & ~out_ready[sel], stall_cnt<=stall_cnt+1. On drain, or when ~full, stall_cnt<=0.
- Timeout, when full & ~out_ready[sel] & stall_cnt==TIMEOUT-1:
  - Mode 0: timeout=1 for one cycle; sel<=sel+1 (word redirected, buffer stays full); ptr<=sel+1; beat_cnt<=0; stall_cnt<=0. Counting restarts on the new destination, and repeated redirects may cycle through all four.
  - Mode 1: timeout=1 for one cycle; stall_cnt saturates at TIMEOUT-1; no redirect. No further pulse until the stall clears.
- timeout is registered.
- Data integrity: a held word is never dropped or duplicated. A redirect changes only the destination of the held word.
- Reset mid-transfer: the buffered word is discarded. The next accepted word goes to destination 0 in mode 0.

Test Plan:
- Reset, mode=0, all out_ready=1, stream 0x10..0x1B continuous → in_ready constantly 1.
  - sel sequence: 0x10–0x13→0, 0x14–0x17→1, 0x18–0x1B→2.
  - out_valid one-hot matches sel; each word appears 1 cycle after accept.
- mode=1, fixed_dst=3, 5 words → all go to out_valid=1000, ptr unchanged.
  - Switch to mode 0 → next word goes to the previous ptr.
- mode=0, out_ready=1101, word 0xAA to dest 1 → in_ready=0 while stalled.
  - After 8 stall cycles: timeout pulse; sel becomes 2; 0xAA drains to dest 2 the next cycle.
  - Next accepted word goes to dest 2.
- mode=1, fixed_dst=0, out_ready[0]=0 for 20 cycles → exactly one timeout pulse at stall cycle 8; word held.
  - Raise out_ready[0] → 0xAA delivered once.
- Back-pressure toggle: out_ready[sel] alternating 1/0 with in_valid=1 → no word lost or duplicated; order preserved; scoreboard of 32 words matches.
- Assert rst_n=0 asynchronously while full → out_valid drops to 0000 immediately, without waiting for a clock edge.
  - After release, the first word goes to dest 0 and beat_cnt restarts.
